// File: rtl/lp_dma_ctrl.sv
// Line-printer DMA controller: fetches bytes from 36-bit bus words and hands
// them one at a time to the printer buffer, with stop and NXM-timeout aborts.
module lp_dma_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lpCMDGO,
  input  logic        lpSTOP,
  input  logic [17:0] lpBARI,
  input  logic [11:0] lpBCTRI,
  input  logic [35:0] lpDATAI,
  input  logic        devACKI,
  input  logic        prREADY,
  output logic        devREQO,
  output logic [17:0] devADDRO,
  output logic [17:0] regBAR,
  output logic [11:0] regBCTR,
  output logic [7:0]  prDATA,
  output logic        prVALID,
  output logic        lpGO,
  output logic        lpDONE,
  output logic        lpNXM
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [17:0] bar_d;
  logic [11:0] bctr_d;
  logic [7:0]  data_d;
  logic [7:0]  timer_q, timer_d;
  logic        done_d;
  logic        nxm_d;
  logic [7:0]  lane_byte;

  // Word-aligned bus address derived from the current byte pointer.
  assign devADDRO = {regBAR[17:2], 2'b00};

  // Byte lane select: the 36-bit word packs bytes at bit offsets 18, 26, 0, 8.
  always_comb begin
    lane_byte = 8'h00;
    case (regBAR[1:0])
      2'b00:   lane_byte = lpDATAI[25:18];
      2'b01:   lane_byte = lpDATAI[33:26];
      2'b10:   lane_byte = lpDATAI[7:0];
      default: lane_byte = lpDATAI[15:8];
    endcase
  end

  // Next-state logic; lpSTOP is checked first so it beats ACK, READY and timeout.
  always_comb begin
    state_d = state_q;
    bar_d   = regBAR;
    bctr_d  = regBCTR;
    data_d  = prDATA;
    done_d  = 1'b0;
    nxm_d   = lpNXM;
    case (state_q)
      StIdle: begin
        if (lpCMDGO) begin
          bar_d  = lpBARI;
          bctr_d = lpBCTRI;
          nxm_d  = 1'b0;
          if (lpBCTRI == 12'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (lpSTOP) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (devACKI) begin
          data_d  = lane_byte;
          state_d = StHold;
        end else if (timer_q == TimeoutVal) begin
          nxm_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StHold: begin
        if (lpSTOP) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (prREADY) begin
          bar_d  = regBAR + 18'd1;
          bctr_d = regBCTR - 12'd1;
          if (regBCTR == 12'd1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Timer only runs across consecutive FETCH cycles; any other path restarts it.
    timer_d = ((state_q == StFetch) && (state_d == StFetch)) ? timer_q + 8'd1 : 8'd0;
  end

  // State and datapath registers; outputs are decoded from next state so they are flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      regBAR  <= 18'd0;
      regBCTR <= 12'd0;
      prDATA  <= 8'd0;
      timer_q <= 8'd0;
      devREQO <= 1'b0;
      prVALID <= 1'b0;
      lpGO    <= 1'b0;
      lpDONE  <= 1'b0;
      lpNXM   <= 1'b0;
    end else begin
      state_q <= state_d;
      regBAR  <= bar_d;
      regBCTR <= bctr_d;
      prDATA  <= data_d;
      timer_q <= timer_d;
      devREQO <= (state_d == StFetch);
      prVALID <= (state_d == StHold);
      lpGO    <= (state_d != StIdle);
      lpDONE  <= done_d;
      lpNXM   <= nxm_d;
    end
  end

endmodule
